sym_freq_count: RTL

- Upstream stage of the Huffman sort.
- Accumulates an occurrence count per symbol over one input block (one pass of a symbol stream).
- Then streams (symbol, count) pairs in ascending symbol order to the sort stage.
- Counts are held in enable-gated registers, one per symbol value; each is cleared as it is handed off, so the block is ready for the next input block.

---
 rtl/sym_freq_count.sv | 73 +++++++
 1 files changed

// File: rtl/sym_freq_count.sv
// sym_freq_count: per-symbol occurrence counter that streams (symbol, count) pairs after each block.
// Optional SYM_FREQ_SKIP_ZERO_EN: emit only nonzero pairs, tracked by a distinct-symbol counter.
module sym_freq_count #(
  parameter int DATA_WIDTH  = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  sym_in,
  input  logic                   sym_valid,
  input  logic                   sym_last,
  output logic                   sym_ready,
  output logic [DATA_WIDTH-1:0]  out_sym,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready
);
  localparam int NUM_SYM = 1 << DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, COUNT, DUMP} state_t;
  state_t r_state, w_next;
  logic [COUNT_WIDTH-1:0] r_cnt [NUM_SYM];
  logic [DATA_WIDTH-1:0]  r_idx;
  logic [COUNT_WIDTH-1:0] w_cur;
  logic w_dump, w_acc, w_hs, w_adv;
  assign w_dump    = r_state == DUMP;
  assign sym_ready = !w_dump;
  assign w_acc     = sym_valid & sym_ready;
  assign w_cur     = r_cnt[r_idx];
  assign w_hs      = out_valid & out_ready;
  assign out_sym   = w_dump ? r_idx : '0;
  assign out_count = w_dump ? w_cur : '0;
`ifdef SYM_FREQ_SKIP_ZERO_EN
  logic [DATA_WIDTH:0] r_distinct, r_emit;
  assign out_valid = w_dump && w_cur != '0;
  assign out_last  = out_valid && (r_emit + 1'b1 == r_distinct);
  // zero entries need no clear, so the index just walks past them
  assign w_adv     = w_hs | (w_dump & w_cur == '0);
  always_ff @(posedge clk) begin
    if (rst || (w_hs && out_last)) begin
      r_distinct <= '0;
      r_emit     <= '0;
    end else begin
      if (w_acc && r_cnt[sym_in] == '0) r_distinct <= r_distinct + 1'b1;
      if (w_hs) r_emit <= r_emit + 1'b1;
    end
  end
`else
  assign out_valid = w_dump;
  assign out_last  = w_dump && &r_idx;
  assign w_adv     = w_hs;
`endif
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = w_dump ? ((w_hs && out_last) ? IDLE : DUMP)
           : w_acc  ? (sym_last ? DUMP : COUNT)
           : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SYM; i++) r_cnt[i] <= '0;
      r_idx <= '0;
    end else begin
      if (w_acc && r_cnt[sym_in] != '1) r_cnt[sym_in] <= r_cnt[sym_in] + 1'b1;
      if (w_hs) r_cnt[r_idx] <= '0;
      if (w_adv) r_idx <= (w_hs && out_last) ? '0 : r_idx + 1'b1;
    end
  end
endmodule
